gray_count_decoder: RTL

//   Receive end of the Gray-coded counter path: samples a Gray count produced by a

---
 rtl/gray_count_decoder.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/gray_count_decoder.sv
// -----------------------------------------------------------------------------
// gray_count_decoder
//   Receive side of a Gray-coded counter link. The Gray input is resynchronised,
//   decoded to binary and checked for exact +1 (mod 2^WIDTH) advances. Once
//   LOCK_COUNT consecutive +1 steps have been seen, the block publishes a
//   validated binary count plus per-step strobes. Any illegal step while locked
//   raises an error and forces the block to reacquire.
//
// Ports
//   clk          in   1      clock, posedge
//   reset_n      in   1      asynchronous active-low reset
//   gray_in      in   WIDTH  Gray-coded count
//   sample_en    in   1      evaluate the synchronised input this cycle
//   clear_err    in   1      clears err_sticky (a same-cycle set wins)
//   bin_count    out  WIDTH  last validated binary count
//   count_valid  out  1      pulse: bin_count advanced by +1
//   wrap         out  1      pulse: the advance was all-ones -> 0
//   step_error   out  1      pulse: illegal step seen while locked
//   locked       out  1      high while in LOCKED
//   err_sticky   out  1      latched step_error, cleared by clear_err
// -----------------------------------------------------------------------------
module gray_count_decoder #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,  // 1..3
  parameter int LOCK_COUNT  = 2   // 1..7
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             sample_en,
  input  logic             clear_err,
  output logic [WIDTH-1:0] bin_count,
  output logic             count_valid,
  output logic             wrap,
  output logic             step_error,
  output logic             locked,
  output logic             err_sticky
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACQ  = 2'd1,
    S_LOCK = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  localparam logic [2:0] LOCK_N = 3'(LOCK_COUNT);

  state_t                            r_state;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
  logic [WIDTH-1:0]                  r_prev;
  logic [WIDTH-1:0]                  r_bin;
  logic [2:0]                        r_ok;
  logic                              r_cv;
  logic                              r_wrap;
  logic                              r_serr;
  logic                              r_locked;
  logic                              r_sticky;

  logic [WIDTH-1:0]                  w_gs;
  logic [WIDTH-1:0]                  w_d;
  logic [WIDTH-1:0]                  w_next;
  logic [2:0]                        w_ok_inc;
  logic                              w_set_err;

  // Input synchroniser; stage 0 takes the raw Gray bus.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
    end else begin
      r_sync[0] <= gray_in;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign w_gs = r_sync[SYNC_STAGES-1];

  // Gray -> binary: bit i is the XOR of all Gray bits at or above i.
  always_comb begin
    w_d = '0;
    for (int i = 0; i < WIDTH; i++) w_d[i] = ^(w_gs >> i);
  end

  assign w_next   = r_prev + WIDTH'(1);   // wraps naturally mod 2^WIDTH
  assign w_ok_inc = r_ok + 3'd1;

  // Illegal step while locked: neither a hold nor a +1.
  assign w_set_err = sample_en && (r_state == S_LOCK) &&
                     (w_d != r_prev) && (w_d != w_next);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_prev   <= '0;
      r_bin    <= '0;
      r_ok     <= '0;
      r_cv     <= 1'b0;
      r_wrap   <= 1'b0;
      r_serr   <= 1'b0;
      r_locked <= 1'b0;
      r_sticky <= 1'b0;
    end else begin
      r_cv   <= 1'b0;
      r_wrap <= 1'b0;
      r_serr <= 1'b0;

      // A new error beats a simultaneous clear.
      if (w_set_err)      r_sticky <= 1'b1;
      else if (clear_err) r_sticky <= 1'b0;

      if (sample_en) begin
        case (r_state)
          S_IDLE: begin
            r_prev   <= w_d;
            r_ok     <= '0;
            r_locked <= 1'b0;
            r_state  <= S_ACQ;
          end
          S_ACQ: begin
            r_prev <= w_d;
            if (w_d == w_next) begin
              r_ok <= w_ok_inc;
              if (w_ok_inc == LOCK_N) begin
                r_bin    <= w_d;
                r_locked <= 1'b1;
                r_state  <= S_LOCK;
              end
            end else if (w_d != r_prev) begin
              r_ok <= '0;
            end
          end
          S_LOCK: begin
            if (w_d == w_next) begin
              r_prev <= w_d;
              r_bin  <= w_d;
              r_cv   <= 1'b1;
              r_wrap <= &r_prev;
            end else if (w_d != r_prev) begin
              // prev and bin_count hold; reacquire starts from the next sample
              r_serr   <= 1'b1;
              r_locked <= 1'b0;
              r_state  <= S_ERR;
            end
          end
          S_ERR: begin
            r_prev   <= w_d;
            r_ok     <= '0;
            r_locked <= 1'b0;
            r_state  <= S_ACQ;
          end
          default: begin
            r_locked <= 1'b0;
            r_state  <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bin_count   = r_bin;
  assign count_valid = r_cv;
  assign wrap        = r_wrap;
  assign step_error  = r_serr;
  assign locked      = r_locked;
  assign err_sticky  = r_sticky;

endmodule
